// File: rtl/alu_sr_seq.sv
// rtl/alu_sr_seq.sv - multi-cycle 32-bit right shifter (SRL/SRA), one log stage per clock; optional rotate via ALU_SR_ROTATE_EN
module alu_sr_seq #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [4:0]       ctrl_shiftamt,
  input  logic             ctrl_arith,
`ifdef ALU_SR_ROTATE_EN
  input  logic             ctrl_rotate,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] work;
  // amt_q is shifted left each stage so bit 4 always selects the current stage
  logic [4:0]       amt_q;
  // stage shift distance: 16, 8, 4, 2, 1
  logic [4:0]       sh;
  logic             arith_q;
  logic             sign_q;
`ifdef ALU_SR_ROTATE_EN
  logic             rot_q;
`endif

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fill;
  logic [WIDTH-1:0] stage_out;

  assign ready = (state == IDLE);

  // one logarithmic stage: shift work right by sh when the selected amount bit is set
  always_comb begin
    shifted   = work >> sh;
    fill      = ~({WIDTH{1'b1}} >> sh);
    stage_out = work;
    if (amt_q[4]) begin
      stage_out = (arith_q && sign_q) ? (shifted | fill) : shifted;
`ifdef ALU_SR_ROTATE_EN
      if (rot_q) begin
        stage_out = shifted | (work << (6'd32 - {1'b0, sh}));
      end
`endif
    end
  end

  // control FSM with operand capture, stage sequencing and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      work    <= '0;
      amt_q   <= 5'd0;
      sh      <= 5'd0;
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
`ifdef ALU_SR_ROTATE_EN
      rot_q   <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work    <= A;
            amt_q   <= ctrl_shiftamt;
            sh      <= 5'd16;
            arith_q <= ctrl_arith;
            sign_q  <= A[WIDTH-1];
`ifdef ALU_SR_ROTATE_EN
            rot_q   <= ctrl_rotate;
`endif
            cnt     <= 3'd0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          work  <= stage_out;
          amt_q <= amt_q << 1;
          sh    <= sh >> 1;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'(STAGES - 1)) begin
            out   <= stage_out;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sr_seq.sv
// tb/tb_alu_sr_seq.sv - self-checking bench for alu_sr_seq
module tb_alu_sr_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [4:0]  ctrl_shiftamt;
  logic        ctrl_arith;
`ifdef ALU_SR_ROTATE_EN
  logic        ctrl_rotate;
`endif
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] out;

  alu_sr_seq dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .A             (A),
    .ctrl_shiftamt (ctrl_shiftamt),
    .ctrl_arith    (ctrl_arith),
`ifdef ALU_SR_ROTATE_EN
    .ctrl_rotate   (ctrl_rotate),
`endif
    .ready         (ready),
    .busy          (busy),
    .done          (done),
    .out           (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  amt;
    logic        arith;
    logic        rot;
    logic [31:0] exp;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  vec_t        vecs[$];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // drives one operation, scrambles operands after accept, checks latency, result and pulse
  task automatic do_op(input logic [31:0] a, input logic [4:0] amt, input logic arith,
                       input logic rot, input logic [31:0] exp, input string name);
    int          lat;
    bit          got;
    logic [31:0] e;
    check(ready === 1'b1, {name, " ready_before"}, 32'(ready), 32'd1);
    A             = a;
    ctrl_shiftamt = amt;
    ctrl_arith    = arith;
`ifdef ALU_SR_ROTATE_EN
    ctrl_rotate   = rot;
`endif
    start = 1'b1;
    sb.push_back(exp);
    @(posedge clock);
    #1;
    start         = 1'b0;
    A             = $urandom;
    ctrl_shiftamt = 5'($urandom);
    ctrl_arith    = ~arith;
`ifdef ALU_SR_ROTATE_EN
    ctrl_rotate   = ~rot;
`endif
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (lat == 1) check(busy === 1'b1 && ready === 1'b0, {name, " busy_in_shift"}, 32'({busy, ready}), 32'b10);
      if (done === 1'b1) got = 1;
    end
    check(got && lat == 5, {name, " latency"}, 32'(lat), 32'd5);
    if (sb.size() == 0) begin
      check(1'b0, {name, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(out === e, {name, " out"}, out, e);
    end
    @(negedge clock);
    check(done === 1'b0 && ready === 1'b1, {name, " done_pulse"}, 32'({done, ready}), 32'b01);
  endtask

  initial begin
    logic [31:0] e;
    logic [31:0] held;
    int          ndone;
    bit          got;
    int          lat;

    reset = 1'b0;
    start = 1'b0;
    A = 32'h0;
    ctrl_shiftamt = 5'd0;
    ctrl_arith = 1'b0;
`ifdef ALU_SR_ROTATE_EN
    ctrl_rotate = 1'b0;
`endif

    vecs.push_back('{32'hF0000000, 5'd4,  1'b1, 1'b0, 32'hFF000000});
    vecs.push_back('{32'h70000000, 5'd4,  1'b1, 1'b0, 32'h07000000});
    vecs.push_back('{32'h12345678, 5'd0,  1'b0, 1'b0, 32'h12345678});
    vecs.push_back('{32'h80000000, 5'd31, 1'b1, 1'b0, 32'hFFFFFFFF});
    vecs.push_back('{32'h80000000, 5'd31, 1'b0, 1'b0, 32'h00000001});
    vecs.push_back('{32'h7FFFFFFF, 5'd31, 1'b0, 1'b0, 32'h00000000});
    vecs.push_back('{32'hDEADBEEF, 5'd8,  1'b0, 1'b0, 32'h00DEADBE});
    vecs.push_back('{32'hDEADBEEF, 5'd8,  1'b1, 1'b0, 32'hFFDEADBE});
    vecs.push_back('{32'hDEADBEEF, 5'd21, 1'b1, 1'b0, 32'hFFFFFEF5});
    vecs.push_back('{32'h5A5A5A5A, 5'd13, 1'b1, 1'b0, 32'h0002D2D2});
`ifdef ALU_SR_ROTATE_EN
    vecs.push_back('{32'h00000001, 5'd1,  1'b0, 1'b1, 32'h80000000});
    vecs.push_back('{32'h12345678, 5'd8,  1'b1, 1'b1, 32'h78123456});
    vecs.push_back('{32'h80000001, 5'd31, 1'b1, 1'b1, 32'h00000003});
`endif

    repeat (2) @(negedge clock);
    check(ready === 1'b1 && busy === 1'b0 && done === 1'b0, "reset_flags", 32'({ready, busy, done}), 32'b100);
    check(out === 32'h0, "reset_out", out, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].amt, vecs[i].arith, vecs[i].rot, vecs[i].exp, $sformatf("vec%0d", i));

    for (int amt = 0; amt < 32; amt++) begin
      e = 32'h80000000 >> amt;
      do_op(32'h80000000, 5'(amt), 1'b0, 1'b0, e, $sformatf("srl_sweep%0d", amt));
    end

    // ignored start during SHIFT and DONE, then result must hold through idle
    A = 32'h12345678;
    ctrl_shiftamt = 5'd8;
    ctrl_arith = 1'b0;
    start = 1'b1;
    sb.push_back(32'h00123456);
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #1 begin start = 1'b1; A = 32'h0; ctrl_shiftamt = 5'd0; end
    @(posedge clock);
    #1 start = 1'b0;
    got = 0;
    lat = 2;
    while (!got && lat < 20) begin
      @(negedge clock);
      if (done === 1'b1) got = 1;
      else begin @(posedge clock); lat++; end
    end
    check(got && lat == 5, "ignore_latency", 32'(lat), 32'd5);
    e = (sb.size() != 0) ? sb.pop_front() : 32'hx;
    check(out === e, "ignore_out", out, e);
    held = out;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
      if (out !== held) ndone += 100;
    end
    check(ndone == 0 && ready === 1'b1, "ignore_no_second_done_hold", 32'(ndone), 32'd0);
    check(out === 32'h00123456, "hold_out", out, 32'h00123456);

    // asynchronous reset mid-operation discards the in-flight result
    A = 32'h80000000;
    ctrl_shiftamt = 5'd4;
    ctrl_arith = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check(out === 32'h0, "midreset_out", out, 32'h0);
    check(busy === 1'b0 && ready === 1'b1 && done === 1'b0, "midreset_flags", 32'({busy, ready, done}), 32'b010);
    @(negedge clock);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
    end
    check(ndone == 0 && out === 32'h0, "midreset_no_done", 32'(ndone), 32'd0);

    do_op(32'hF0000000, 5'd4, 1'b1, 1'b0, 32'hFF000000, "after_reset");
    check(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sr_seq.md
Name: alu_sr_seq

Overview:
- Multi-cycle 32-bit right shifter: logical (SRL) or arithmetic (SRA). It is the right-direction companion of the combinational left shifter in the ALU.
- Uses a 5-stage logarithmic decomposition with one stage per clock (16, 8, 4, 2, 1), trading latency for area.
- Sits beside the ALU; the processor control issues start and waits for done, which gives it a start/done handshake.

Parameters:
- WIDTH, 32, data width; must be 32 (shift amount fixed at 5 bits).
- STAGES, 5, number of shift stages; equals log2(WIDTH).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when ready=1
- A  input  32  operand; captured at accepted start
- ctrl_shiftamt  input  5  shift amount 0..31; captured at accepted start
- ctrl_arith  input  1  1=SRA (fill with A[31]), 0=SRL (fill with 0); captured at accepted start
- ready  output  1  1 when state==IDLE (combinational from state)
- busy  output  1  1 in SHIFT state
- done  output  1  one-cycle pulse; out valid
- out  output  32  result; held until the next accepted start or reset

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, stage counter=0, working reg=0, out=0, done=0, busy=0, ready=1. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States:
  - IDLE: ready=1. If start=1 at edge N, capture A, amt, arith into internal regs, clear counter, go to SHIFT.
  - SHIFT: busy=1. At each edge, stage k (k=0..4, shift 16>>k) is applied:
    - if amt[4-k]=1, work = work shifted right by 16>>k, filled with A[31] (arith) or 0;
    - otherwise work is unchanged.
    - The counter increments each edge. After stage 4 the next state is DONE and out<=final value.
  - DONE: done=1, busy=0, ready=0 for exactly one cycle, then IDLE.
- Timing: start accepted at edge N; stages applied at edges N+1..N+5; done=1 and out valid in the cycle after edge N+5. IDLE again after edge N+6.
  - Fixed latency of 5 cycles regardless of amount. Throughput is one operation per 7 cycles.
- The sign bit used for fill is the captured A[31], not the current input.
- Changes on A/ctrl_* after capture have no effect.
- start while busy or in DONE: ignored, not queued.
- ctrl_shiftamt=0: passes through all stages unchanged; out=A, still 5-cycle latency.
- ctrl_shiftamt=31 SRA on a negative operand: out=32'hFFFFFFFF. SRL: out=0 or 1 depending on A[31].
- out retains the last result through IDLE. It is overwritten only at the DONE transition of the next operation.

Optional Feature:
- Macro: ALU_SR_ROTATE_EN.
- Defined:
  - Adds input port ctrl_rotate (1 bit), captured with the other operands.
  - ctrl_rotate=1 gives rotate-right: bits shifted out of bit 0 re-enter at bit 31. ctrl_arith is ignored.
  - Same latency and handshake.
- Undefined: port absent; behaviour is SRL/SRA only.

Test Plan:
- Reset mid-operation: start A=32'h80000000, amt=4, arith=1; assert reset at cycle 3 -> out=0, busy=0, ready=1 immediately. No done after release.
- SRL sweep: A=32'h80000000, arith=0, amt=0..31 each -> done exactly 5 cycles after accept; out=32'h80000000>>amt (amt=31 -> 32'h00000001).
- SRA sign fill: A=32'hF0000000, amt=4, arith=1 -> out=32'hFF000000. A=32'h70000000, amt=4 -> out=32'h07000000.
- Ignored start / operand stability: during SHIFT, pulse start and change A to 32'h0 -> first result is unaffected, no second done. out holds the value through 10 idle cycles.
- Zero/max boundary: A=32'h12345678, amt=0 -> out=32'h12345678. A=32'h80000000, amt=31, arith=1 -> out=32'hFFFFFFFF.
- With ALU_SR_ROTATE_EN: A=32'h00000001, amt=1, ctrl_rotate=1 -> out=32'h80000000. A=32'h12345678, amt=8 -> out=32'h78123456.
